// File: rtl/serial_compare_scheduler.sv
// Round-robin scheduler sharing one MSB-first bit-serial magnitude comparator among N_REQ requesters.
// Optional build macro SERIAL_CMP_EARLY_EXIT_EN: finish as soon as the first differing bit is seen.
module serial_compare_scheduler #(
    parameter int N_REQ = 4,
    parameter int WIDTH = 8,
    localparam int IDW = $clog2(N_REQ)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [N_REQ-1:0]       req_valid,
    output logic [N_REQ-1:0]       req_ready,
    input  logic [N_REQ*WIDTH-1:0] req_a,
    input  logic [N_REQ*WIDTH-1:0] req_b,
    output logic                   res_valid,
    input  logic                   res_ready,
    output logic [IDW-1:0]         res_id,
    output logic                   res_less,
    output logic                   res_eq,
    output logic                   res_greater,
    output logic                   busy
);

    localparam int IW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SHIFT,
        ST_RESULT
    } state_t;

    state_t state_reg, state_next;

    logic [IDW-1:0]   rr_ptr_reg;
    logic [IDW-1:0]   id_reg;
    logic [WIDTH-1:0] a_sh_reg, b_sh_reg;
    logic [IW-1:0]    idx_reg;
    logic             eq_reg, less_reg, greater_reg;
    logic [IDW-1:0]   res_id_reg;
    logic             res_less_reg, res_eq_reg, res_greater_reg;

    logic             grant_found;
    logic [IDW-1:0]   grant_id;
    logic             accept;
    logic [WIDTH-1:0] a_word [N_REQ];
    logic [WIDTH-1:0] b_word [N_REQ];

    generate
        for (genvar gi = 0; gi < N_REQ; gi++) begin : g_req
            assign a_word[gi]    = req_a[gi*WIDTH +: WIDTH];
            assign b_word[gi]    = req_b[gi*WIDTH +: WIDTH];
            assign req_ready[gi] = accept && (grant_id == IDW'(gi));
        end
    endgenerate

    // Scan from rr_ptr downward in priority so the closest valid requester wins.
    always_comb begin : grant_search
        int pos;
        pos         = 0;
        grant_found = 1'b0;
        grant_id    = '0;
        for (int k = N_REQ - 1; k >= 0; k--) begin
            pos = int'(rr_ptr_reg) + k;
            if (pos >= N_REQ) begin
                pos = pos - N_REQ;
            end
            if (req_valid[IDW'(pos)]) begin
                grant_found = 1'b1;
                grant_id    = IDW'(pos);
            end
        end
    end

    assign accept = (state_reg == ST_IDLE) && !rst && grant_found;

    logic a_bit, b_bit, bit_diff, last_bit, leave_shift;
    logic eq_next, less_next, greater_next;

    assign a_bit    = a_sh_reg[WIDTH-1];
    assign b_bit    = b_sh_reg[WIDTH-1];
    assign bit_diff = a_bit ^ b_bit;
    assign last_bit = (idx_reg == '0);

    // The first differing bit decides the verdict; later bits cannot change it.
    assign eq_next      = eq_reg & ~bit_diff;
    assign less_next    = (eq_reg && bit_diff) ? ~a_bit : less_reg;
    assign greater_next = (eq_reg && bit_diff) ? a_bit : greater_reg;

`ifdef SERIAL_CMP_EARLY_EXIT_EN
    assign leave_shift = last_bit || (eq_reg && bit_diff);
`else
    assign leave_shift = last_bit;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= ST_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_IDLE: begin
                if (grant_found) begin
                    state_next = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                if (leave_shift) begin
                    state_next = ST_RESULT;
                end
            end
            ST_RESULT: begin
                if (res_ready) begin
                    state_next = ST_IDLE;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rr_ptr_reg      <= '0;
            id_reg          <= '0;
            a_sh_reg        <= '0;
            b_sh_reg        <= '0;
            idx_reg         <= '0;
            eq_reg          <= 1'b1;
            less_reg        <= 1'b0;
            greater_reg     <= 1'b0;
            res_id_reg      <= '0;
            res_eq_reg      <= 1'b1;
            res_less_reg    <= 1'b0;
            res_greater_reg <= 1'b0;
        end else begin
            case (state_reg)
                ST_IDLE: begin
                    if (grant_found) begin
                        a_sh_reg    <= a_word[grant_id];
                        b_sh_reg    <= b_word[grant_id];
                        id_reg      <= grant_id;
                        idx_reg     <= IW'(WIDTH - 1);
                        eq_reg      <= 1'b1;
                        less_reg    <= 1'b0;
                        greater_reg <= 1'b0;
                    end
                end
                ST_SHIFT: begin
                    a_sh_reg    <= a_sh_reg << 1;
                    b_sh_reg    <= b_sh_reg << 1;
                    idx_reg     <= idx_reg - IW'(1);
                    eq_reg      <= eq_next;
                    less_reg    <= less_next;
                    greater_reg <= greater_next;
                    // Result fields only move here, so they stay frozen outside this transfer.
                    if (leave_shift) begin
                        res_id_reg      <= id_reg;
                        res_eq_reg      <= eq_next;
                        res_less_reg    <= less_next;
                        res_greater_reg <= greater_next;
                    end
                end
                ST_RESULT: begin
                    if (res_ready) begin
                        rr_ptr_reg <= (id_reg == IDW'(N_REQ - 1)) ? '0 : id_reg + IDW'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    assign res_valid   = (state_reg == ST_RESULT);
    assign res_id      = res_id_reg;
    assign res_less    = res_less_reg;
    assign res_eq      = res_eq_reg;
    assign res_greater = res_greater_reg;
    assign busy        = (state_reg != ST_IDLE);

endmodule

// File: tb/tb_serial_compare_scheduler.sv
// Directed self-checking bench for serial_compare_scheduler (N_REQ=4, WIDTH=8).
module tb_serial_compare_scheduler;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  req_valid;
    logic [3:0]  req_ready;
    logic [31:0] req_a;
    logic [31:0] req_b;
    logic        res_valid;
    logic        res_ready;
    logic [1:0]  res_id;
    logic        res_less, res_eq, res_greater;
    logic        busy;

    int checks = 0;
    int errors = 0;

`ifdef SERIAL_CMP_EARLY_EXIT_EN
    localparam int LAT_MSB_DIFF = 2;
`else
    localparam int LAT_MSB_DIFF = 9;
`endif
    localparam int LAT_FULL = 9;

    serial_compare_scheduler #(.N_REQ(4), .WIDTH(8)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_a(req_a), .req_b(req_b),
        .res_valid(res_valid), .res_ready(res_ready),
        .res_id(res_id), .res_less(res_less), .res_eq(res_eq), .res_greater(res_greater),
        .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic reset_dut();
        rst = 1'b1;
        req_valid = '0;
        res_ready = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    // Presents one job, returns the sampled req_ready and cycles from accept to res_valid.
    // Operands are inverted right after accept so late changes would corrupt the verdict.
    task automatic run_job(input logic [3:0] mask, input int id, input logic [7:0] a,
                           input logic [7:0] b, output logic [3:0] rdy, output int lat);
        @(negedge clk);
        req_a[id*8 +: 8] = a;
        req_b[id*8 +: 8] = b;
        req_valid = mask;
        #1 rdy = req_ready;
        @(negedge clk);
        req_valid = '0;
        req_a[id*8 +: 8] = ~a;
        req_b[id*8 +: 8] = ~b;
        lat = 1;
        while (res_valid !== 1'b1 && lat < 40) begin
            @(negedge clk);
            lat++;
        end
    endtask

    task automatic finish_result();
        res_ready = 1'b1;
        @(negedge clk);
        res_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        req_valid = 4'hF;
        res_ready = 1'b0;
        req_a = '0;
        req_b = '0;
        repeat (2) @(negedge clk);
        checks++;
        if (req_ready !== 4'b0000) begin errors++; $display("FAIL reset_ready got=%b exp=0000", req_ready); end
        checks++;
        if ({res_valid, busy} !== 2'b00) begin errors++; $display("FAIL reset_valid_busy got=%b exp=00", {res_valid, busy}); end
        checks++;
        if ({res_id, res_less, res_eq, res_greater} !== 5'b00_010) begin
            errors++; $display("FAIL reset_fields got=%b exp=00010", {res_id, res_less, res_eq, res_greater});
        end
        rst = 1'b0;
        req_valid = '0;
        $display("reset: checked idle outputs");
    endtask

    task automatic test_equal();
        logic [3:0] rdy;
        int lat;
        run_job(4'b0001, 0, 8'hA5, 8'hA5, rdy, lat);
        checks++;
        if (rdy !== 4'b0001) begin errors++; $display("FAIL eq_ready got=%b exp=0001", rdy); end
        checks++;
        if (lat != LAT_FULL) begin errors++; $display("FAIL eq_latency got=%0d exp=%0d", lat, LAT_FULL); end
        checks++;
        if ({res_id, res_less, res_eq, res_greater} !== 5'b00_010) begin
            errors++; $display("FAIL eq_result got=%b exp=00010", {res_id, res_less, res_eq, res_greater});
        end
        finish_result();
        checks++;
        if (res_valid !== 1'b0) begin errors++; $display("FAIL eq_release got=%b exp=0", res_valid); end
        $display("equal: A=A5 B=A5 id=%0d lat=%0d", res_id, lat);
    endtask

    task automatic test_greater();
        logic [3:0] rdy;
        int lat;
        run_job(4'b0100, 2, 8'h80, 8'h7F, rdy, lat);
        checks++;
        if (rdy !== 4'b0100) begin errors++; $display("FAIL gt_ready got=%b exp=0100", rdy); end
        checks++;
        if (lat != LAT_MSB_DIFF) begin errors++; $display("FAIL gt_latency got=%0d exp=%0d", lat, LAT_MSB_DIFF); end
        checks++;
        if ({res_id, res_less, res_eq, res_greater} !== 5'b10_001) begin
            errors++; $display("FAIL gt_result got=%b exp=10001", {res_id, res_less, res_eq, res_greater});
        end
        finish_result();
        $display("greater: A=80 B=7F id=%0d lat=%0d", res_id, lat);
    endtask

    task automatic test_less();
        logic [3:0] rdy;
        int lat;
        run_job(4'b0010, 1, 8'h00, 8'hFF, rdy, lat);
        checks++;
        if (rdy !== 4'b0010) begin errors++; $display("FAIL lt_ready got=%b exp=0010", rdy); end
        checks++;
        if (lat != LAT_MSB_DIFF) begin errors++; $display("FAIL lt_latency got=%0d exp=%0d", lat, LAT_MSB_DIFF); end
        checks++;
        if ({res_id, res_less, res_eq, res_greater} !== 5'b01_100) begin
            errors++; $display("FAIL lt_result got=%b exp=01100", {res_id, res_less, res_eq, res_greater});
        end
        finish_result();
        $display("less: A=00 B=FF id=%0d lat=%0d", res_id, lat);
    endtask

    task automatic test_lsb_diff();
        logic [3:0] rdy;
        int lat;
        // rr_ptr is 2 here; the scan 2,3,0 finds requester 0 only after wrapping.
        run_job(4'b0001, 0, 8'h54, 8'h55, rdy, lat);
        checks++;
        if (rdy !== 4'b0001) begin errors++; $display("FAIL lsb_ready got=%b exp=0001", rdy); end
        checks++;
        if (lat != LAT_FULL) begin errors++; $display("FAIL lsb_latency got=%0d exp=%0d", lat, LAT_FULL); end
        checks++;
        if ({res_id, res_less, res_eq, res_greater} !== 5'b00_100) begin
            errors++; $display("FAIL lsb_result got=%b exp=00100", {res_id, res_less, res_eq, res_greater});
        end
        finish_result();
        $display("lsb_diff: A=54 B=55 id=%0d lat=%0d", res_id, lat);
    endtask

    task automatic test_back_to_back();
        int exp_id [5] = '{0, 1, 2, 3, 0};
        logic [2:0] exp_flags [4] = '{3'b100, 3'b010, 3'b001, 3'b100};
        int got;
        int cyc;
        reset_dut();
        req_a = 32'h10_C9_33_01;
        req_b = 32'h20_84_33_02;
        req_valid = 4'hF;
        res_ready = 1'b1;
        got = 0;
        cyc = 0;
        while (got < 5 && cyc < 300) begin
            @(negedge clk);
            cyc++;
            if (res_valid === 1'b1) begin
                checks++;
                if (res_id !== 2'(exp_id[got])) begin
                    errors++; $display("FAIL rr_id[%0d] got=%0d exp=%0d", got, res_id, exp_id[got]);
                end
                checks++;
                if ({res_less, res_eq, res_greater} !== exp_flags[exp_id[got]]) begin
                    errors++; $display("FAIL rr_flags[%0d] got=%b exp=%b", got, {res_less, res_eq, res_greater}, exp_flags[exp_id[got]]);
                end
                $display("back_to_back: result %0d id=%0d lge=%b", got, res_id, {res_less, res_eq, res_greater});
                got++;
            end
        end
        checks++;
        if (got != 5) begin errors++; $display("FAIL rr_count got=%0d exp=5", got); end
        req_valid = '0;
        res_ready = 1'b0;
    endtask

    task automatic test_stall();
        logic [3:0] rdy;
        int lat;
        int bad;
        reset_dut();
        run_job(4'b0100, 2, 8'h30, 8'h31, rdy, lat);
        checks++;
        if (lat != LAT_FULL) begin errors++; $display("FAIL stall_latency got=%0d exp=%0d", lat, LAT_FULL); end
        req_valid = 4'hF;
        bad = 0;
        for (int i = 0; i < 5; i++) begin
            #1;
            if ({res_valid, res_id, res_less, res_eq, res_greater} !== 6'b1_10_100 || req_ready !== 4'b0000) bad++;
            @(negedge clk);
        end
        checks++;
        if (bad != 0) begin errors++; $display("FAIL stall_hold bad_cycles=%0d exp=0", bad); end
        res_ready = 1'b1;
        #1;
        checks++;
        if (req_ready !== 4'b0000) begin errors++; $display("FAIL stall_handshake_ready got=%b exp=0000", req_ready); end
        @(negedge clk);
        res_ready = 1'b0;
        #1;
        checks++;
        if (req_ready !== 4'b1000) begin errors++; $display("FAIL stall_next_grant got=%b exp=1000", req_ready); end
        req_valid = '0;
        $display("stall: held 5 cycles, next grant=%b", req_ready);
    endtask

    task automatic test_reset_abort();
        int seen;
        reset_dut();
        @(negedge clk);
        req_a[15:8] = 8'h00;
        req_b[15:8] = 8'h01;
        req_valid = 4'b0010;
        #1;
        checks++;
        if (req_ready !== 4'b0010) begin errors++; $display("FAIL abort_accept got=%b exp=0010", req_ready); end
        seen = 0;
        @(negedge clk);
        req_valid = '0;
        if (res_valid === 1'b1) seen++;
        @(negedge clk);
        if (res_valid === 1'b1) seen++;
        @(negedge clk);
        if (res_valid === 1'b1) seen++;
        rst = 1'b1;
        req_valid = 4'hF;
        #1;
        checks++;
        if (req_ready !== 4'b0000) begin errors++; $display("FAIL abort_ready_in_rst got=%b exp=0000", req_ready); end
        @(negedge clk);
        rst = 1'b0;
        req_valid = '0;
        checks++;
        if (busy !== 1'b0) begin errors++; $display("FAIL abort_busy got=%b exp=0", busy); end
        for (int i = 0; i < 15; i++) begin
            @(negedge clk);
            if (res_valid === 1'b1) seen++;
        end
        checks++;
        if (seen != 0) begin errors++; $display("FAIL abort_no_result got=%0d exp=0", seen); end
        req_valid = 4'hF;
        #1;
        checks++;
        if (req_ready !== 4'b0001) begin errors++; $display("FAIL abort_next_grant got=%b exp=0001", req_ready); end
        @(negedge clk);
        req_valid = '0;
        $display("reset_abort: results seen=%0d", seen);
    endtask

    initial begin
        test_reset();
        test_equal();
        test_greater();
        test_less();
        test_lsb_diff();
        test_back_to_back();
        test_stall();
        test_reset_abort();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
